ndp_result_drain: RTL and testbench

//  Downstream stage of the NDP systolic compute unit. Snapshots the full result matrix out_c

---
 rtl/ndp_result_drain.sv | 122 ++++++++++++
 tb/tb_ndp_result_drain.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ndp_result_drain.sv
// Result drain: snapshots the compute-unit result matrix on a done rising edge and streams it
// row-major as BEAT_ELEMS-wide valid/ready beats. Optional NDP_DRAIN_RELU_EN zeroes negative lanes.
module ndp_result_drain #(
  parameter int WIDTH      = 16,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int BEAT_ELEMS = 16,
  localparam int R      = ARR_HEIGHT * SYS_HEIGHT,
  localparam int C      = ARR_WIDTH * SYS_WIDTH,
  localparam int N      = R * C,
  localparam int BEATS  = N / BEAT_ELEMS,
  localparam int BPR    = C / BEAT_ELEMS,
  localparam int BEAT_W = BEAT_ELEMS * WIDTH,
  localparam int RW     = (R > 1) ? $clog2(R) : 1,
  localparam int CW     = (BPR > 1) ? $clog2(BPR) : 1,
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                calc_done_flag,
  input  logic [N*WIDTH-1:0]  in_c,
  output logic [BEAT_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RW-1:0]       out_row,
  output logic [CW-1:0]       out_col_beat,
  output logic                out_last,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              done_q;
  logic              overrun_q, overrun_d;
  logic              load;
  logic              rise, hs, last_beat;
  logic [BEAT_W-1:0] snap_q [BEATS];
  logic [BEAT_W-1:0] beat_word;
  logic [WIDTH-1:0]  lane;

  assign rise      = calc_done_flag & ~done_q;
  assign hs        = out_valid & out_ready;
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // A rise coinciding with the final handshake is a back-to-back reload, not an overrun.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          load    = 1'b1;
          beat_d  = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs && last_beat) begin
          beat_d = '0;
          if (rise) load = 1'b1;
          else      state_d = S_IDLE;
        end else begin
          if (hs)   beat_d = beat_q + 1'b1;
          if (rise) overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // done_q resets high so a level already asserted at reset release is not a new result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      done_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      done_q    <= calc_done_flag;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int b = 0; b < BEATS; b++) snap_q[b] <= in_c[b*BEAT_W +: BEAT_W];
    end
  end

  assign beat_word = snap_q[beat_q];

  always_comb begin
    out_data = '0;
    lane     = '0;
    if (out_valid) begin
      for (int m = 0; m < BEAT_ELEMS; m++) begin
        lane = beat_word[m*WIDTH +: WIDTH];
`ifdef NDP_DRAIN_RELU_EN
        if (lane[WIDTH-1]) lane = '0;
`endif
        out_data[m*WIDTH +: WIDTH] = lane;
      end
    end
  end

  assign out_valid    = (state_q == S_STREAM);
  assign busy         = out_valid;
  assign overrun      = overrun_q;
  assign out_row      = RW'(32'(beat_q) / BPR);
  assign out_col_beat = CW'(32'(beat_q) % BPR);
  assign out_last     = out_valid & last_beat;

endmodule

// File: tb/tb_ndp_result_drain.sv
// Bench for ndp_result_drain: matrix-level reference model checked every cycle, plus directed
// boundary checks (reset, back-to-back reload, overrun, async abort, sign-lane zeroing).
module tb_ndp_result_drain;
  localparam int NE    = 1024;
  localparam int BEATS = 64;
  localparam int BE    = 16;

  logic              clk, reset, calc_done_flag, out_ready;
  logic [NE*16-1:0]  in_c;
  logic [BE*16-1:0]  out_data;
  logic              out_valid, out_last, busy, overrun;
  logic [1:0]        out_row;
  logic [3:0]        out_col_beat;

  ndp_result_drain dut (
    .clk(clk), .reset(reset), .calc_done_flag(calc_done_flag), .in_c(in_c),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col_beat(out_col_beat), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int dut_acc = 0;

  logic [15:0] cur_mat [NE];
  logic [15:0] m_mat   [NE];
  bit          m_valid, m_overrun, m_prev_done;
  int          m_beat;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] post(input logic [15:0] v);
`ifdef NDP_DRAIN_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic set_in();
    for (int e = 0; e < NE; e++) in_c[e*16 +: 16] = cur_mat[e];
  endtask

  task automatic rand_mat();
    for (int e = 0; e < NE; e++) cur_mat[e] = 16'($urandom);
    set_in();
  endtask

  task automatic model_reset();
    m_valid = 0; m_overrun = 0; m_prev_done = 1; m_beat = 0;
  endtask

  task automatic check_outputs();
    logic [255:0] exp_d;
    chk("valid", 256'(out_valid), 256'(m_valid));
    chk("busy", 256'(busy), 256'(m_valid));
    chk("overrun", 256'(overrun), 256'(m_overrun));
    if (m_valid) begin
      exp_d = '0;
      for (int m = 0; m < BE; m++) exp_d[m*16 +: 16] = post(m_mat[m_beat*BE + m]);
      chk("data", out_data, exp_d);
      chk("row", 256'(out_row), 256'(m_beat / 16));
      chk("col_beat", 256'(out_col_beat), 256'(m_beat % 16));
      chk("last", 256'(out_last), 256'(m_beat == BEATS - 1));
    end else begin
      chk("data_gated", out_data, 256'(0));
      chk("last_idle", 256'(out_last), 256'(0));
    end
  endtask

  // Advance one clock: apply the matrix-level rules to the inputs present at this edge.
  task automatic tick();
    bit rise, hs, fin, was_valid;
    rise      = calc_done_flag && !m_prev_done;
    was_valid = m_valid;
    hs        = m_valid && out_ready;
    fin       = hs && (m_beat == BEATS - 1);
    if (was_valid && rise && !fin) m_overrun = 1;
    if (hs) m_beat++;
    if (fin) m_valid = 0;
    if (rise && (!was_valid || fin)) begin
      m_mat = cur_mat; m_beat = 0; m_valid = 1;
    end
    m_prev_done = calc_done_flag;
    if (out_valid && out_ready) dut_acc++;
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic drain(input bit rnd_ready);
    for (int k = 0; k < 3000 && m_valid; k++) begin
      if (rnd_ready) out_ready = 1'($urandom);
      tick();
    end
    out_ready = 1'b1;
    chk("drain_done", 256'(out_valid), 256'(0));
  endtask

  task automatic run_to_beat(input int b);
    for (int k = 0; k < 200 && m_beat != b; k++) tick();
    chk("reach_beat", 256'(m_valid && m_beat == b), 256'(1));
  endtask

  initial begin
    int acc0;
    reset = 1'b0; calc_done_flag = 1'b1; out_ready = 1'b0; in_c = '0;
    for (int e = 0; e < NE; e++) cur_mat[e] = 16'(e);
    set_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_row", 256'(out_row), 256'(0));
    chk("rst_col", 256'(out_col_beat), 256'(0));
    chk("rst_data", out_data, 256'(0));
    reset = 1'b1;

    // Done level held through reset release must not start a stream.
    repeat (4) tick();
    calc_done_flag = 1'b0; tick();
    calc_done_flag = 1'b1; out_ready = 1'b1;
    tick();
    chk("first_beat_latency", 256'(out_valid), 256'(1));
    calc_done_flag = 1'b0;
    for (int k = 1; k <= BEATS; k++) begin
      tick();
      if (k == 17) begin
        chk("beat17_lane0", 256'(out_data[15:0]), 256'(272));
        chk("beat17_lane15", 256'(out_data[255:240]), 256'(287));
        chk("beat17_row", 256'(out_row), 256'(1));
        chk("beat17_col", 256'(out_col_beat), 256'(1));
      end
      if (k == BEATS - 1) chk("last_on_63", 256'(out_last), 256'(1));
    end
    chk("stream1_end", 256'(out_valid), 256'(0));

    // Random backpressure.
    rand_mat();
    acc0 = dut_acc;
    calc_done_flag = 1'b1; out_ready = 1'b0; tick();
    calc_done_flag = 1'b0;
    drain(1'b1);
    chk("beats_accepted", 256'(dut_acc - acc0), 256'(BEATS));

    // Overrun mid-stream, then back-to-back reload on the last handshake.
    rand_mat();
    calc_done_flag = 1'b1; tick();
    calc_done_flag = 1'b0;
    run_to_beat(10);
    rand_mat();
    calc_done_flag = 1'b1; tick();
    calc_done_flag = 1'b0; tick();
    chk("overrun_set", 256'(overrun), 256'(1));
    run_to_beat(BEATS - 1);
    rand_mat();
    calc_done_flag = 1'b1; tick();
    chk("reload_no_bubble", 256'(out_valid), 256'(1));
    chk("reload_beat0_row", 256'(out_row), 256'(0));
    chk("reload_overrun_kept", 256'(overrun), 256'(1));
    calc_done_flag = 1'b0;
    drain(1'b1);

    // Asynchronous abort at beat 30.
    rand_mat();
    calc_done_flag = 1'b1; tick();
    calc_done_flag = 1'b0;
    run_to_beat(30);
    reset = 1'b0;
    #2;
    chk("abort_valid", 256'(out_valid), 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_overrun", 256'(overrun), 256'(0));
    model_reset();
    reset = 1'b1;
    tick();
    rand_mat();
    calc_done_flag = 1'b1; tick();
    chk("restart_col", 256'(out_col_beat), 256'(0));
    calc_done_flag = 1'b0;
    drain(1'b0);

    // Sign-lane handling.
    rand_mat();
    cur_mat[0] = 16'hBC00; cur_mat[1] = 16'h8000; cur_mat[2] = 16'h3C00;
    set_in();
    calc_done_flag = 1'b1; tick();
    calc_done_flag = 1'b0;
`ifdef NDP_DRAIN_RELU_EN
    chk("relu_lane0", 256'(out_data[15:0]), 256'(16'h0000));
    chk("relu_lane1", 256'(out_data[31:16]), 256'(16'h0000));
`else
    chk("raw_lane0", 256'(out_data[15:0]), 256'(16'hBC00));
    chk("raw_lane1", 256'(out_data[31:16]), 256'(16'h8000));
`endif
    chk("pos_lane2", 256'(out_data[47:32]), 256'(16'h3C00));
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
